// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-vector helpers for the AXI-Stream header extractor.
// Helpers work on a wide keep vector; callers size-cast the result to their beat width.
package axis_hdr_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam int MAX_BYTES = 64;
    typedef logic [MAX_BYTES-1:0] keep_max_t;

    function automatic int popcount(input keep_max_t keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            n += int'(keep[i]);
        end
        return n;
    endfunction

    // n enables packed against the MSB end of a total-byte beat (byte 0 = MSB byte)
    function automatic keep_max_t keep_left(input int n, input int total);
        keep_max_t k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < total && i >= total - n) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

    function automatic keep_max_t keep_right(input int n);
        keep_max_t k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/byte_realigner.sv
// Combinational byte realigner: joins the carried residual with a new beat and
// splits off the header, the realigned payload word and the next residual.
module byte_realigner
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      residual,
    input  logic [DATA_WD-1:0]      beat,
    input  logic [BYTE_CNT_WD:0]    h,
    input  logic [BYTE_CNT_WD:0]    c,
    output logic [DATA_WD-1:0]      hdr_word,
    output logic [DATA_WD-1:0]      out_word,
    output logic [DATA_BYTE_WD-1:0] out_keep,
    output logic [DATA_WD-1:0]      new_residual,
    output logic [DATA_WD-1:0]      tail_word
);

    typedef logic [BYTE_CNT_WD:0]    cnt_t;
    typedef logic [DATA_BYTE_WD-1:0] keep_t;

    localparam cnt_t N_BYTES = cnt_t'(DATA_BYTE_WD);

    cnt_t                r;
    cnt_t                take;
    keep_t               low_keep;
    logic [DATA_WD-1:0]  low_mask;

    always_comb begin
        r        = N_BYTES - h;
        take     = (c < h) ? c : h;
        low_keep = keep_t'(keep_right(int'(r)));
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            low_mask[i*8 +: 8] = {8{low_keep[i]}};
        end

        // Residual sits right-aligned in the upper word, so the window that starts
        // at its first byte begins r bytes above the bottom of the concatenation.
        out_word     = DATA_WD'({residual, beat} >> {r, 3'b000});
        out_keep     = keep_t'(keep_left(int'(r + take), DATA_BYTE_WD));
        hdr_word     = beat >> {r, 3'b000};
        new_residual = beat & low_mask;
        tail_word    = new_residual << {h, 3'b000};
    end

endmodule

// File: rtl/axi_stream_extract_header.sv
// AXI-Stream header stripper: splits the leading hdr_len bytes off each packet onto
// a header channel and left-realigns the payload. Define HDR_ERR_CHECK_EN for err_hdr.
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD:0]    hdr_len,

    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,

    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr
`ifdef HDR_ERR_CHECK_EN
    ,
    output logic                    err_hdr
`endif
);

    typedef logic [BYTE_CNT_WD:0]    cnt_t;
    typedef logic [DATA_BYTE_WD-1:0] keep_t;

    localparam cnt_t N_BYTES = cnt_t'(DATA_BYTE_WD);

    state_t             state;
    cnt_t               h_q;
    cnt_t               tail_cnt_q;
    logic [DATA_WD-1:0] residual_q;

    logic [DATA_WD-1:0] beat_m;
    cnt_t               c;
    cnt_t               h_cur;
    logic               pay_free;
    logic               hdr_free;
    logic               accept;
    logic               bad_hdr;
    logic               drop_q;

    logic [DATA_WD-1:0] hdr_word;
    logic [DATA_WD-1:0] out_word;
    keep_t              out_keep;
    logic [DATA_WD-1:0] new_residual;
    logic [DATA_WD-1:0] tail_word;

    // NOTE: every byte of beat_m is written on every pass, so no latch can form.
    always_comb begin
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            beat_m[i*8 +: 8] = data_in[i*8 +: 8] & {8{keep_in[i]}};
        end
    end

    assign c        = cnt_t'(popcount(keep_max_t'(keep_in)));
    assign h_cur    = (state == IDLE) ? hdr_len : h_q;
    assign pay_free = !valid_out || ready_out;
    assign hdr_free = !valid_hdr || ready_hdr;
    assign ready_in = pay_free && (state != FLUSH) && ((state != IDLE) || hdr_free);
    assign accept   = valid_in && ready_in;

`ifdef HDR_ERR_CHECK_EN
    assign bad_hdr = (hdr_len == '0) || (hdr_len > N_BYTES) || (last_in && (c < hdr_len));
`else
    assign bad_hdr = 1'b0;
    assign drop_q  = 1'b0;
`endif

    byte_realigner #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .residual     (residual_q),
        .beat         (beat_m),
        .h            (h_cur),
        .c            (c),
        .hdr_word     (hdr_word),
        .out_word     (out_word),
        .out_keep     (out_keep),
        .new_residual (new_residual),
        .tail_word    (tail_word)
    );

    // NOTE: non-blocking assignments throughout; a later load in the case below
    // overrides the handshake clear at the top of the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            h_q        <= '0;
            tail_cnt_q <= '0;
            residual_q <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            keep_out   <= '0;
            last_out   <= 1'b0;
            valid_hdr  <= 1'b0;
            data_hdr   <= '0;
            keep_hdr   <= '0;
`ifdef HDR_ERR_CHECK_EN
            err_hdr    <= 1'b0;
            drop_q     <= 1'b0;
`endif
        end else begin
            if (valid_out && ready_out) valid_out <= 1'b0;
            if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && !bad_hdr) begin
                        h_q       <= hdr_len;
                        valid_hdr <= 1'b1;
                        data_hdr  <= hdr_word;
                        keep_hdr  <= keep_t'(keep_right(int'(hdr_len)));
                        if (!last_in) begin
                            residual_q <= new_residual;
                            state      <= STREAM;
                        end else if (c > hdr_len) begin
                            valid_out <= 1'b1;
                            data_out  <= tail_word;
                            keep_out  <= keep_t'(keep_left(int'(c - hdr_len), DATA_BYTE_WD));
                            last_out  <= 1'b1;
                        end
                    end
`ifdef HDR_ERR_CHECK_EN
                    else if (accept) begin
                        err_hdr <= 1'b1;
                        if (!last_in) begin
                            drop_q <= 1'b1;
                            state  <= STREAM;
                        end
                    end
`endif
                end

                STREAM: begin
                    if (accept && !drop_q) begin
                        valid_out <= 1'b1;
                        data_out  <= out_word;
                        keep_out  <= out_keep;
                        if (!last_in) begin
                            last_out   <= 1'b0;
                            residual_q <= new_residual;
                        end else if (c <= h_q) begin
                            last_out   <= 1'b1;
                            residual_q <= '0;
                            state      <= IDLE;
                        end else begin
                            // Final beat overflows: hold its tail, already left-aligned
                            last_out   <= 1'b0;
                            residual_q <= tail_word;
                            tail_cnt_q <= c - h_q;
                            state      <= FLUSH;
                        end
                    end
`ifdef HDR_ERR_CHECK_EN
                    else if (accept && last_in) begin
                        drop_q <= 1'b0;
                        state  <= IDLE;
                    end
`endif
                end

                FLUSH: begin
                    if (pay_free) begin
                        valid_out  <= 1'b1;
                        data_out   <= residual_q;
                        keep_out   <= keep_t'(keep_left(int'(tail_cnt_q), DATA_BYTE_WD));
                        last_out   <= 1'b1;
                        residual_q <= '0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Self-checking bench for axi_stream_extract_header (32-bit): directed vectors,
// backpressure, mid-packet reset and randomized packets against a byte-queue model.
module tb_axi_stream_extract_header;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [2:0]  hlen;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } out_t;

    typedef struct {
        int               hlen;
        int               nb;
        logic [0:2][31:0] din;
        logic [0:2][3:0]  kin;
        logic [31:0]      hdr_d;
        logic [3:0]       hdr_k;
        int               np;
        logic [0:2][31:0] pd;
        logic [0:2][3:0]  pk;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic [2:0]  hdr_len;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_hdr;
    logic [31:0] data_hdr;
    logic [3:0]  keep_hdr;
    logic        ready_hdr;
`ifdef HDR_ERR_CHECK_EN
    logic        err_hdr;
`endif

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .keep_in   (keep_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .hdr_len   (hdr_len),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out),
        .ready_out (ready_out),
        .valid_hdr (valid_hdr),
        .data_hdr  (data_hdr),
        .keep_hdr  (keep_hdr),
        .ready_hdr (ready_hdr)
`ifdef HDR_ERR_CHECK_EN
        ,
        .err_hdr   (err_hdr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t in_q[$];
    out_t  exp_pay[$];
    out_t  got_pay[$];
    out_t  exp_hdr[$];
    out_t  got_hdr[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_mode = 1'b0;
    int   hold_out = 0;
    int   hold_hdr = 0;
    bit   in_fire = 1'b0;
    bit   po_stall = 1'b0;
    bit   ph_stall = 1'b0;
    out_t po_prev;
    out_t ph_prev;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Driver: inputs change 1 time unit after the rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                valid_in = 1'b0;
            end else if (!(valid_in && !in_fire)) begin
                if (in_q.size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                    valid_in = 1'b1;
                    data_in  = in_q[0].data;
                    keep_in  = in_q[0].keep;
                    last_in  = in_q[0].last;
                    hdr_len  = in_q[0].hlen;
                end else begin
                    valid_in = 1'b0;
                    data_in  = $urandom;
                end
            end
            in_fire = 1'b0;
            if (hold_out > 0 && valid_out) begin
                ready_out = 1'b0;
                hold_out--;
            end else begin
                ready_out = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (hold_hdr > 0 && valid_hdr) begin
                ready_hdr = 1'b0;
                hold_hdr--;
            end else begin
                ready_hdr = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: handshakes sampled on the falling edge, between drive and capture
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                po_stall = 1'b0;
                ph_stall = 1'b0;
            end else begin
                if (po_stall) begin
                    check("hold_valid_out", 64'(valid_out), 64'(1));
                    check("hold_data_out", 64'({data_out, keep_out, last_out}), 64'(po_prev));
                end
                if (ph_stall) begin
                    check("hold_valid_hdr", 64'(valid_hdr), 64'(1));
                    check("hold_data_hdr", 64'({data_hdr, keep_hdr}), 64'({ph_prev.data, ph_prev.keep}));
                end
                if (valid_out && !ready_out) check("stall_ready_in", 64'(ready_in), 64'(0));
                po_stall = valid_out && !ready_out;
                ph_stall = valid_hdr && !ready_hdr;
                po_prev  = '{data: data_out, keep: keep_out, last: last_out};
                ph_prev  = '{data: data_hdr, keep: keep_hdr, last: 1'b0};
                if (valid_in && ready_in && in_q.size() > 0) begin
                    in_fire = 1'b1;
                    void'(in_q.pop_front());
                end
                if (valid_out && ready_out) got_pay.push_back('{data: data_out, keep: keep_out, last: last_out});
                if (valid_hdr && ready_hdr) got_hdr.push_back('{data: data_hdr, keep: keep_hdr, last: 1'b0});
            end
        end
    end

    // Reference model: the packet is a byte list; the first h bytes are the header,
    // the rest is re-chunked into left-aligned 4-byte beats.
    task automatic push_model_pkt(input int h, input int nb, input int lc);
        byte unsigned bytes[$];
        logic [31:0]  d;
        logic [3:0]   k;
        int           c;
        for (int b = 0; b < nb; b++) begin
            d = $urandom;
            c = (b == nb - 1) ? lc : 4;
            k = 4'(4'hF << (4 - c));
            in_q.push_back('{data: d, keep: k, last: (b == nb - 1), hlen: 3'(h)});
            for (int j = 0; j < c; j++) bytes.push_back(d[31-8*j -: 8]);
        end
        d = '0;
        for (int j = 0; j < h; j++) d = {d[23:0], bytes[j]};
        exp_hdr.push_back('{data: d, keep: 4'((1 << h) - 1), last: 1'b0});
        for (int p = h; p < bytes.size(); p += 4) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                d = {d[23:0], (p + j < bytes.size()) ? bytes[p+j] : 8'h00};
                k = {k[2:0], (p + j < bytes.size())};
            end
            exp_pay.push_back('{data: d, keep: k, last: (p + 4 >= bytes.size())});
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int b = 0; b < v.nb; b++)
            in_q.push_back('{data: v.din[b], keep: v.kin[b], last: (b == v.nb - 1), hlen: 3'(v.hlen)});
        exp_hdr.push_back('{data: v.hdr_d, keep: v.hdr_k, last: 1'b0});
        for (int p = 0; p < v.np; p++)
            exp_pay.push_back('{data: v.pd[p], keep: v.pk[p], last: (p == v.np - 1)});
    endtask

    task automatic run_and_compare(input string name);
        int cyc;
        int n;
        cyc = 0;
        while ((in_q.size() != 0 || got_pay.size() < exp_pay.size() || got_hdr.size() < exp_hdr.size())
               && cyc < 4000) begin
            @(posedge clk);
            cyc++;
        end
        check({name, "_timeout"}, 64'(cyc < 4000), 64'(1));
        repeat (6) @(posedge clk);
        check({name, "_n_pay"}, 64'(got_pay.size()), 64'(exp_pay.size()));
        check({name, "_n_hdr"}, 64'(got_hdr.size()), 64'(exp_hdr.size()));
        n = (got_hdr.size() < exp_hdr.size()) ? got_hdr.size() : exp_hdr.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_hdr%0d", name, i), 64'({got_hdr[i].data, got_hdr[i].keep}),
                  64'({exp_hdr[i].data, exp_hdr[i].keep}));
        n = (got_pay.size() < exp_pay.size()) ? got_pay.size() : exp_pay.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_pay%0d", name, i), 64'(got_pay[i]), 64'(exp_pay[i]));
        got_pay.delete();
        exp_pay.delete();
        got_hdr.delete();
        exp_hdr.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        keep_in   = '0;
        last_in   = 1'b0;
        hdr_len   = 3'd1;
        ready_out = 1'b1;
        ready_hdr = 1'b1;

        vecs[0] = '{2, 3, {32'hAABBCCDD, 32'h11223344, 32'h55660000}, {4'hF, 4'hF, 4'hC},
                    32'h0000AABB, 4'h3, 2, {32'hCCDD1122, 32'h33445566, 32'h0}, {4'hF, 4'hF, 4'h0}};
        vecs[1] = '{1, 2, {32'hAABBCCDD, 32'h11223300, 32'h0}, {4'hF, 4'hE, 4'h0},
                    32'h000000AA, 4'h1, 2, {32'hBBCCDD11, 32'h22330000, 32'h0}, {4'hF, 4'hC, 4'h0}};
        vecs[2] = '{4, 3, {32'hAABBCCDD, 32'h01020304, 32'h05060000}, {4'hF, 4'hF, 4'hC},
                    32'hAABBCCDD, 4'hF, 2, {32'h01020304, 32'h05060000, 32'h0}, {4'hF, 4'hC, 4'h0}};
        vecs[3] = '{2, 1, {32'hAABBCCDD, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0},
                    32'h0000AABB, 4'h3, 1, {32'hCCDD0000, 32'h0, 32'h0}, {4'hC, 4'h0, 4'h0}};
        vecs[4] = '{2, 1, {32'hAABBCCDD, 32'h0, 32'h0}, {4'hC, 4'h0, 4'h0},
                    32'h0000AABB, 4'h3, 0, {32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0}};
        vecs[5] = '{3, 1, {32'hAABBCCDD, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0},
                    32'h00AABBCC, 4'h7, 1, {32'hDD000000, 32'h0, 32'h0}, {4'h8, 4'h0, 4'h0}};
        vecs[6] = '{4, 1, {32'hAABBCCDD, 32'h0, 32'h0}, {4'hF, 4'h0, 4'h0},
                    32'hAABBCCDD, 4'hF, 0, {32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0}};
        vecs[7] = '{3, 2, {32'h12345678, 32'h9ABCDEF0, 32'h0}, {4'hF, 4'h8, 4'h0},
                    32'h00123456, 4'h7, 1, {32'h789A0000, 32'h0, 32'h0}, {4'hC, 4'h0, 4'h0}};
        vecs[8] = '{1, 2, {32'h01020304, 32'h05060708, 32'h0}, {4'hF, 4'hF, 4'h0},
                    32'h00000001, 4'h1, 2, {32'h02030405, 32'h06070800, 32'h0}, {4'hF, 4'hE, 4'h0}};
        vecs[9] = '{1, 1, {32'hAA112233, 32'h0, 32'h0}, {4'h8, 4'h0, 4'h0},
                    32'h000000AA, 4'h1, 0, {32'h0, 32'h0, 32'h0}, {4'h0, 4'h0, 4'h0}};

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_valid_hdr", 64'(valid_hdr), 64'(0));
        check("rst_payload_regs", 64'({data_out, keep_out, last_out}), 64'(0));
        check("rst_header_regs", 64'({data_hdr, keep_hdr}), 64'(0));
`ifdef HDR_ERR_CHECK_EN
        check("rst_err_hdr", 64'(err_hdr), 64'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        check("idle_ready_in", 64'(ready_in), 64'(1));

        for (int i = 0; i < 10; i++) begin
            push_vec(vecs[i]);
            run_and_compare($sformatf("vec%0d", i));
        end

        // Backpressure on both output channels while a packet streams through
        hold_out = 3;
        hold_hdr = 2;
        push_vec(vecs[0]);
        push_vec(vecs[2]);
        run_and_compare("backpressure");

        // Reset while in STREAM, then a fresh packet must be treated as a first beat
        in_q.push_back('{data: 32'hAABBCCDD, keep: 4'hF, last: 1'b0, hlen: 3'd2});
        in_q.push_back('{data: 32'h11223344, keep: 4'hF, last: 1'b0, hlen: 3'd2});
        for (int cyc = 0; cyc < 200 && in_q.size() != 0; cyc++) @(posedge clk);
        check("mid_pkt_drained", 64'(in_q.size()), 64'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_out", 64'(valid_out), 64'(0));
        check("mid_rst_valid_hdr", 64'(valid_hdr), 64'(0));
        in_q.delete();
        got_pay.delete();
        got_hdr.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        push_model_pkt(3, 3, 2);
        run_and_compare("after_reset");

        rand_mode = 1'b1;
        for (int batch = 0; batch < 4; batch++) begin
            for (int p = 0; p < 50; p++) begin
                int h;
                int nb;
                int lc;
                h  = $urandom_range(1, 4);
                nb = $urandom_range(1, 4);
                lc = (nb == 1) ? $urandom_range(h, 4) : $urandom_range(1, 4);
                push_model_pkt(h, nb, lc);
            end
            run_and_compare($sformatf("random%0d", batch));
        end
        rand_mode = 1'b0;

`ifdef HDR_ERR_CHECK_EN
        in_q.push_back('{data: 32'hDEADBEEF, keep: 4'hF, last: 1'b1, hlen: 3'd0});
        push_model_pkt(2, 2, 3);
        run_and_compare("err_then_good");
        check("err_hdr_set", 64'(err_hdr), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
